// File: rtl/chr_tile_fetcher.sv
// chr_tile_fetcher: reads both CHR bitplanes for one tile row and streams eight 2-bit pixels.
// Define CHR_FLIP_EN to latch and apply the horizontal/vertical flip request bits.
module chr_tile_fetcher #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_table,
   input  logic [7:0]        req_tile,
   input  logic [2:0]        req_row,
   input  logic              req_flip_h,
   input  logic              req_flip_v,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [1:0]        pix_data,
   output logic              pix_last
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH_LO,
      FETCH_HI,
      SHIFT
   } state_t;

   state_t            state_q, state_d;
   logic              table_q, table_d;
   logic [7:0]        tile_q, tile_d;
   logic [2:0]        row_q, row_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        lo_q, lo_d;
   logic [7:0]        hi_q, hi_d;
   logic [2:0]        count_q, count_d;
   logic [2:0]        row_eff;
   logic [2:0]        bit_idx;

`ifdef CHR_FLIP_EN
   logic              flip_h_q, flip_h_d;
`else
   logic              unused_flip;
   assign unused_flip = req_flip_h | req_flip_v;
`endif

   // CHR address layout: table | tile | plane | row, zero-extended to the port width.
   function automatic logic [ADDR_W-1:0] chr_addr(input logic       tbl,
                                                  input logic [7:0] tile,
                                                  input logic       plane,
                                                  input logic [2:0] row);
      logic [12:0] a;
      a = {tbl, tile, plane, row};
      return ADDR_W'(a);
   endfunction

   always_comb begin
      state_d = state_q;
      table_d = table_q;
      tile_d  = tile_q;
      row_d   = row_q;
      addr_d  = addr_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      count_d = count_q;
`ifdef CHR_FLIP_EN
      flip_h_d = flip_h_q;
      row_eff  = req_flip_v ? ~req_row : req_row;
`else
      row_eff  = req_row;
`endif

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               table_d = req_table;
               tile_d  = req_tile;
               row_d   = row_eff;
`ifdef CHR_FLIP_EN
               flip_h_d = req_flip_h;
`endif
               addr_d  = chr_addr(req_table, req_tile, 1'b0, row_eff);
               state_d = FETCH_LO;
            end
         end
         FETCH_LO: begin
            lo_d    = mem_rdata;
            addr_d  = chr_addr(table_q, tile_q, 1'b1, row_q);
            state_d = FETCH_HI;
         end
         FETCH_HI: begin
            hi_d    = mem_rdata;
            count_d = 3'd0;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (pix_ready) begin
               if (count_q == 3'd7) begin
                  count_d = 3'd0;
                  state_d = IDLE;
               end else begin
                  count_d = count_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         table_q <= 1'b0;
         tile_q  <= 8'd0;
         row_q   <= 3'd0;
         addr_q  <= '0;
         lo_q    <= 8'd0;
         hi_q    <= 8'd0;
         count_q <= 3'd0;
`ifdef CHR_FLIP_EN
         flip_h_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         table_q <= table_d;
         tile_q  <= tile_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         count_q <= count_d;
`ifdef CHR_FLIP_EN
         flip_h_q <= flip_h_d;
`endif
      end
   end

   // Bit 7 leaves first unless a horizontal flip was latched with the request.
   always_comb begin
`ifdef CHR_FLIP_EN
      bit_idx = flip_h_q ? count_q : ~count_q;
`else
      bit_idx = ~count_q;
`endif
   end

   assign req_ready = (state_q == IDLE) && !reset;
   assign mem_addr  = addr_q;
   assign mem_we    = 1'b0;
   assign mem_wdata = 8'd0;
   assign pix_valid = (state_q == SHIFT);
   assign pix_data  = pix_valid ? {hi_q[bit_idx], lo_q[bit_idx]} : 2'b00;
   assign pix_last  = pix_valid && (count_q == 3'd7);

endmodule

// File: tb/tb_chr_tile_fetcher.sv
// Scoreboard bench for chr_tile_fetcher: random CHR contents, random requests and consumer stalls.
// Compile with CHR_FLIP_EN defined for both files to exercise the flip path.
module tb_chr_tile_fetcher;

   localparam int ADDR_W = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_table;
   logic [7:0]        req_tile;
   logic [2:0]        req_row;
   logic              req_flip_h;
   logic              req_flip_v;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              pix_valid;
   logic              pix_ready;
   logic [1:0]        pix_data;
   logic              pix_last;

   chr_tile_fetcher #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_table (req_table),
      .req_tile  (req_tile),
      .req_row   (req_row),
      .req_flip_h(req_flip_h),
      .req_flip_v(req_flip_v),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_data  (pix_data),
      .pix_last  (pix_last)
   );

   always #5 clk = ~clk;

   // CHR memory: samples the address on the falling edge, data is seen at the next rising edge.
   logic [7:0] chr_mem [0:8191];
   always @(negedge clk) mem_rdata <= chr_mem[mem_addr[12:0]];

   int tests = 0;
   int errors = 0;
   bit rand_ready = 1'b0;

   task automatic check_output(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_addr(input int tbl, input int tile, input int plane, input int row);
      return tbl * 4096 + tile * 16 + plane * 8 + row;
   endfunction

   // Scoreboard state: expected pixels as {last, data}, plus the pending address sequence.
   logic [2:0] exp_q [$];
   logic [2:0] entry;
   int         phase = 0;
   int         exp_lo = 0;
   int         exp_hi = 0;
   int         pix_seen = 0;
   bit         rst_prev = 1'b0;
   bit         last_pend = 1'b0;
   bit         prev_stall = 1'b0;
   bit         prev_cont = 1'b0;
   logic [1:0] held_data;
   logic       held_last;
   int         m_row, m_lo, m_hi, m_b;
   bit         m_busy;

   always @(negedge clk) begin
      check_output("mem_we", int'(mem_we), 0);
      check_output("mem_wdata", int'(mem_wdata), 0);
      if (rst_prev) begin
         check_output("rst_pix_valid", int'(pix_valid), 0);
         check_output("rst_pix_last", int'(pix_last), 0);
         check_output("rst_pix_data", int'(pix_data), 0);
         check_output("rst_mem_addr", int'(mem_addr), 0);
         check_output("rst_req_ready", int'(req_ready), int'(!reset));
      end
      if (reset) begin
         check_output("ready_in_reset", int'(req_ready), 0);
         exp_q.delete();
         phase      = 0;
         last_pend  = 1'b0;
         prev_stall = 1'b0;
         prev_cont  = 1'b0;
         rst_prev   = 1'b1;
      end else begin
         rst_prev = 1'b0;
         m_busy   = (phase != 0) || (exp_q.size() != 0);
         if (m_busy)
            check_output("ready_while_busy", int'(req_ready), 0);
         if (last_pend) begin
            check_output("valid_after_row", int'(pix_valid), 0);
            check_output("ready_after_row", int'(req_ready), 1);
            last_pend = 1'b0;
         end
         if (phase == 1) begin
            check_output("addr_lo", int'(mem_addr), exp_lo);
            check_output("valid_fetch_lo", int'(pix_valid), 0);
            phase = 2;
         end else if (phase == 2) begin
            check_output("addr_hi", int'(mem_addr), exp_hi);
            check_output("valid_fetch_hi", int'(pix_valid), 0);
            phase = 3;
         end else if (phase == 3) begin
            check_output("first_pix_latency", int'(pix_valid), 1);
            phase = 0;
         end
         if (prev_stall) begin
            check_output("hold_valid", int'(pix_valid), 1);
            check_output("hold_data", int'(pix_data), int'(held_data));
            check_output("hold_last", int'(pix_last), int'(held_last));
         end
         if (prev_cont)
            check_output("pix_back_to_back", int'(pix_valid), 1);
         prev_stall = 1'b0;
         prev_cont  = 1'b0;
         if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
               check_output("unexpected_pixel", 1, 0);
            end else begin
               entry = exp_q.pop_front();
               check_output("pix_data", int'(pix_data), int'(entry[1:0]));
               check_output("pix_last", int'(pix_last), int'(entry[2]));
               pix_seen++;
               if (entry[2]) last_pend = 1'b1;
               else prev_cont = 1'b1;
            end
         end else if (pix_valid) begin
            prev_stall = 1'b1;
            held_data  = pix_data;
            held_last  = pix_last;
         end
         if (req_valid && req_ready) begin
            m_row = int'(req_row);
`ifdef CHR_FLIP_EN
            if (req_flip_v) m_row = 7 - int'(req_row);
`endif
            exp_lo = ref_addr(int'(req_table), int'(req_tile), 0, m_row);
            exp_hi = ref_addr(int'(req_table), int'(req_tile), 1, m_row);
            m_lo   = int'(chr_mem[exp_lo]);
            m_hi   = int'(chr_mem[exp_hi]);
            for (int i = 0; i < 8; i++) begin
               m_b = 7 - i;
`ifdef CHR_FLIP_EN
               if (req_flip_h) m_b = i;
`endif
               exp_q.push_back(3'(((i == 7) ? 4 : 0) + ((m_hi >> m_b) & 1) * 2 + ((m_lo >> m_b) & 1)));
            end
            phase = 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) pix_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic apply_stimulus(input logic tbl, input logic [7:0] tile, input logic [2:0] row,
                                 input logic fh, input logic fv);
      int guard = 0;
      bit done = 1'b0;
      req_valid  = 1'b1;
      req_table  = tbl;
      req_tile   = tile;
      req_row    = row;
      req_flip_h = fh;
      req_flip_v = fv;
      while (!done && guard < 200) begin
         @(negedge clk);
         if (req_ready && !reset) done = 1'b1;
         tick();
         guard++;
      end
      check_output("accept_timeout", int'(done), 1);
      req_valid  = 1'b0;
      req_table  = 1'($urandom);
      req_tile   = 8'($urandom);
      req_row    = 3'($urandom);
      req_flip_h = 1'($urandom);
      req_flip_v = 1'($urandom);
   endtask

   task automatic wait_pix(input int n);
      int base = pix_seen;
      int guard = 0;
      while (pix_seen < base + n && guard < 200) begin
         tick();
         guard++;
      end
      check_output("wait_pix_timeout", int'(pix_seen >= base + n), 1);
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((exp_q.size() != 0 || phase != 0 || last_pend) && guard < 400) begin
         tick();
         guard++;
      end
      check_output("drain_timeout", int'(guard < 400), 1);
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_table  = 1'b0;
      req_tile   = 8'd0;
      req_row    = 3'd0;
      req_flip_h = 1'b0;
      req_flip_v = 1'b0;
      pix_ready  = 1'b1;
      for (int i = 0; i < 8192; i++) chr_mem[i] = 8'($urandom);
      repeat (3) tick();
      reset = 1'b0;
      tick();

      chr_mem[13'h0013] = 8'hA5;
      chr_mem[13'h001B] = 8'h0F;
      chr_mem[13'h0014] = 8'h3C;
      chr_mem[13'h001C] = 8'h96;
      apply_stimulus(1'b0, 8'h01, 3'd3, 1'b0, 1'b0);
      wait_idle();
      apply_stimulus(1'b1, 8'hFF, 3'd7, 1'b0, 1'b0);
      wait_idle();
      apply_stimulus(1'b0, 8'h01, 3'd3, 1'b1, 1'b0);
      wait_idle();
      apply_stimulus(1'b0, 8'h01, 3'd3, 1'b0, 1'b1);
      wait_idle();
      apply_stimulus(1'b0, 8'h01, 3'd3, 1'b1, 1'b1);
      wait_idle();

      // Consumer stall at the fourth pixel while a competing request is held.
      apply_stimulus(1'b0, 8'h01, 3'd3, 1'b0, 1'b0);
      wait_pix(3);
      pix_ready = 1'b0;
      req_valid = 1'b1;
      req_table = 1'b1;
      req_tile  = 8'h5A;
      req_row   = 3'd2;
      repeat (5) tick();
      req_valid = 1'b0;
      pix_ready = 1'b1;
      wait_idle();

      // Reset while the high plane is being fetched, then a clean row.
      apply_stimulus(1'b1, 8'h42, 3'd6, 1'b0, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      apply_stimulus(1'b0, 8'h22, 3'd5, 1'b0, 1'b0);
      wait_idle();

      // Reset while the fifth pixel is presented, then a clean row.
      apply_stimulus(1'b1, 8'h81, 3'd1, 1'b0, 1'b0);
      wait_pix(4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      apply_stimulus(1'b0, 8'h01, 3'd3, 1'b0, 1'b0);
      wait_idle();

      rand_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
         apply_stimulus(1'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      end
      rand_ready = 1'b0;
      pix_ready  = 1'b1;
      wait_idle();
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d tests %0d failed", tests, errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/chr_tile_fetcher.md
# chr_tile_fetcher

Pattern-table read initiator for the PPU background/sprite path. Accepts one tile-row request (table, tile index, row), issues the two bitplane reads to the CHR memory, captures the low and high plane bytes and serializes them as eight 2-bit pixel indices over a valid/ready stream. It is the reading side of the CHR memory port: it drives address/write-enable and consumes the memory's registered read data.

## Interface

Parameters:
- ADDR_W, 16, CHR memory address width; must be ≥ 13; upper bits driven 0.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  fetcher idle and able to accept.
- req_table  in  1  pattern table select (address bit 12).
- req_tile  in  8  tile index (address bits 11:4).
- req_row  in  3  row within tile (address bits 2:0).
- req_flip_h  in  1  emit pixels LSB-first (honoured only with CHR_FLIP_EN).
- req_flip_v  in  1  use row 7-req_row (honoured only with CHR_FLIP_EN).
- mem_addr  out  ADDR_W  CHR memory address.
- mem_we  out  1  CHR memory write enable; constant 0.
- mem_wdata  out  8  CHR memory write data; constant 0.
- mem_rdata  in  8  CHR memory read data; valid at the rising edge following the edge that set mem_addr (memory samples address and registers data on the falling edge).
- pix_valid  out  1  pixel present.
- pix_ready  in  1  consumer accepts pixel.
- pix_data  out  2  pixel index {hi_bit, lo_bit}.
- pix_last  out  1  eighth pixel of the row.

## Operation

- Address: mem_addr = {0…, table, tile, plane, row_eff}; plane 0 = low byte, 1 = high byte (bit 3); row_eff = req_row, or 7-req_row when flip_v active.
- Request fields, including flip bits, are registered on acceptance; inputs ignored afterwards.
- States:
  - IDLE: req_ready=1. On req_valid: latch fields, mem_addr <= low-plane address, go FETCH_LO.
  - FETCH_LO: lo_reg <= mem_rdata; mem_addr <= high-plane address; go FETCH_HI.
  - FETCH_HI: hi_reg <= mem_rdata; bit counter <= 0; go SHIFT.
  - SHIFT: pix_valid=1; pix_data = {hi_reg[b], lo_reg[b]}, b = 7-count (no flip) or count (flip_h). On pix_valid&&pix_ready: count++; at count 7 go IDLE.
- pix_last = 1 exactly when in SHIFT and count == 7.
- pix_data/pix_last held stable while pix_valid && !pix_ready.
- req_valid while not IDLE: ignored, not queued (req_ready=0).
- mem_addr holds its last value in IDLE and SHIFT.
- Reset (any state, including mid-fetch or mid-shift): state IDLE, pix_valid=0, pix_last=0, pix_data=0, mem_addr=0, counter 0, lo_reg/hi_reg=0, mem_we=0; req_ready=0 during the reset cycle, 1 on the first cycle after reset deasserts. Partial row discarded, no pixels emitted.

## Timing

- Accept edge E0 → mem_addr = low address in cycle after E0; lo captured at E1; hi captured at E2; pix_valid=1 from E2.
- Latency accept → first pixel: 2 cycles. Minimum occupancy per row: 11 cycles (1 IDLE + 2 fetch + 8 pixels) with pix_ready held high.
- After final pixel handshake, req_ready=1 the next cycle; no back-to-back overlap.
- All outputs registered or decoded from registered state only; no combinational path from pix_ready or req_valid to any output.

## Configuration

- CHR_FLIP_EN defined: req_flip_h and req_flip_v latched and applied as above.
- CHR_FLIP_EN undefined: flip inputs ignored (no flops inferred); row_eff = req_row, pixels always bit 7 first.

## Test plan

- Table 0, tile 0x01, row 3 → mem_addr 0x0013 then 0x001B; mem_we always 0.
- Table 1, tile 0xFF, row 7 → mem_addr 0x1FF7 then 0x1FFF.
- lo=0xA5, hi=0x0F, pix_ready=1 → pix_data 1,0,1,0,2,3,2,3 on consecutive cycles starting 2 cycles after accept; pix_last only on 8th; req_ready=1 the cycle after.
- CHR_FLIP_EN, same data, flip_h=1 → 3,2,3,2,0,1,0,1; flip_v=1 with tile 0x01 row 3 → addresses 0x0014/0x001C.
- pix_ready low 5 cycles at pixel 4 → pix_data/pix_last held, count unchanged; new req_valid during SHIFT ignored (req_ready=0).
- reset pulsed during FETCH_HI and at pixel 5 → next cycle pix_valid=0, mem_addr=0; req_ready=1 after reset drops; subsequent request produces a full correct 8-pixel row.
